pattern_buf: RTL and testbench



---
 rtl/pattern_buf_pkg.sv | 20 ++
 rtl/pattern_field_rot.sv | 22 ++
 rtl/pattern_buf.sv | 144 ++++++++++++++
 tb/tb_pattern_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_buf_pkg.sv
// Shared types and default geometry for the pattern buffer bank.
package pattern_buf_pkg;

  // Default geometry; the top module derives its own constants from its parameters.
  localparam int DEF_BUFP_WIDTH   = 3;
  localparam int DEF_FIELDP_WIDTH = 5;
  localparam int DEF_BUFFER_WIDTH = 8;

  localparam int NUM_BUFS      = 2 ** DEF_BUFP_WIDTH;
  localparam int BUF_BITS      = 2 ** DEF_FIELDP_WIDTH;
  localparam int BYTES_PER_BUF = BUF_BITS / DEF_BUFFER_WIDTH;

  // Ownership of one buffer: stream fills it, processor owns it, stream drains it.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    RELEASED = 2'd2
  } buf_state_t;

endpackage

// File: rtl/pattern_field_rot.sv
// Circular bit rotate: dout[i] = din[(i + shift) mod 2^SHIFT_W].
// The source vector length is a power of two, so the SHIFT_W-bit add wraps for free.
module pattern_field_rot
  import pattern_buf_pkg::*;
#(
  parameter int SHIFT_W = DEF_FIELDP_WIDTH,
  parameter int OUT_W   = 2 ** DEF_FIELDP_WIDTH
) (
  input  logic [(2**SHIFT_W)-1:0] din,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [OUT_W-1:0]        dout
);

  // Each output bit picks the source bit shift positions above it, wrapping around.
  always_comb begin
    dout = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dout[i] = din[SHIFT_W'(i) + shift];
    end
  end

endmodule

// File: rtl/pattern_buf.sv
// Bank of bit-addressable pattern buffers: filled from a byte stream, handed to
// the processor for field-level read/modify, then drained in round-robin order.
module pattern_buf
  import pattern_buf_pkg::*;
#(
  parameter int BUFP_WIDTH   = DEF_BUFP_WIDTH,
  parameter int FIELDP_WIDTH = DEF_FIELDP_WIDTH,
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BUFP_WIDTH-1:0]        bufp,
  input  logic [FIELDP_WIDTH-1:0]      fieldp,
  input  logic [FIELDP_WIDTH-1:0]      fieldwp,
  input  logic                         field_we,
  input  logic [BUFFER_WIDTH-1:0]      field_wdata,
  output logic [BUFFER_WIDTH-1:0]      field_rdata,
  input  logic                         buf_release,
  output logic [(2**BUFP_WIDTH)-1:0]   buf_full,
  input  logic                         in_valid,
  input  logic [BUFFER_WIDTH-1:0]      in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [BUFFER_WIDTH-1:0]      out_data,
  input  logic                         out_ready
);

  localparam int NBUF   = 2 ** BUFP_WIDTH;
  localparam int BITS   = 2 ** FIELDP_WIDTH;
  localparam int NBYTE  = BITS / BUFFER_WIDTH;
  localparam int BYTE_W = (NBYTE > 1) ? $clog2(NBYTE) : 1;

  buf_state_t                state     [NBUF];
  buf_state_t                state_nxt [NBUF];
  logic [BITS-1:0]           mem       [NBUF];

  logic [BUFP_WIDTH-1:0]     fill_idx;
  logic [BYTE_W-1:0]         fill_byte;
  logic [BUFP_WIDTH-1:0]     drain_idx;
  logic [BYTE_W-1:0]         drain_byte;

  logic                      fill_hs, fill_last;
  logic                      drain_hs, drain_last;
  logic                      wr_ok, rel_ok;
  logic [FIELDP_WIDTH-1:0]   fill_base, drain_base, wr_shift;
  logic [BITS-1:0]           wr_mask, wr_data;
  logic [BUFFER_WIDTH-1:0]   rd_field;

  assign fill_base  = FIELDP_WIDTH'(fill_byte * BUFFER_WIDTH);
  assign drain_base = FIELDP_WIDTH'(drain_byte * BUFFER_WIDTH);

  assign in_ready   = (state[fill_idx] == EMPTY);
  assign fill_hs    = in_valid && in_ready;
  assign fill_last  = (fill_byte == BYTE_W'(NBYTE - 1));

  assign out_valid  = (state[drain_idx] == RELEASED);
  assign out_data   = mem[drain_idx][drain_base +: BUFFER_WIDTH];
  assign drain_hs   = out_valid && out_ready;
  assign drain_last = (drain_byte == BYTE_W'(NBYTE - 1));

  // Field accesses only touch a buffer while the processor owns it.
  assign wr_ok      = field_we && (state[bufp] == FULL);
  assign rel_ok     = buf_release && (state[bufp] == FULL);

  // Rotating right by -fieldwp places bit i of the field at fieldwp+i.
  assign wr_shift   = '0 - fieldwp;

  pattern_field_rot #(.SHIFT_W(FIELDP_WIDTH), .OUT_W(BUFFER_WIDTH)) u_rd_rot (
    .din   (mem[bufp]),
    .shift (fieldp),
    .dout  (rd_field)
  );

  pattern_field_rot #(.SHIFT_W(FIELDP_WIDTH), .OUT_W(BITS)) u_wmask_rot (
    .din   ({{(BITS-BUFFER_WIDTH){1'b0}}, {BUFFER_WIDTH{1'b1}}}),
    .shift (wr_shift),
    .dout  (wr_mask)
  );

  pattern_field_rot #(.SHIFT_W(FIELDP_WIDTH), .OUT_W(BITS)) u_wdata_rot (
    .din   ({{(BITS-BUFFER_WIDTH){1'b0}}, field_wdata}),
    .shift (wr_shift),
    .dout  (wr_data)
  );

  // Next ownership state; fill, release and drain always act on buffers in different states.
  always_comb begin
    state_nxt = state;
    if (fill_hs && fill_last)   state_nxt[fill_idx]  = FULL;
    if (rel_ok)                 state_nxt[bufp]      = RELEASED;
    if (drain_hs && drain_last) state_nxt[drain_idx] = EMPTY;
  end

  // Ownership state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) state[i] <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill and drain pointers advance byte by byte, then buffer by buffer with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_idx   <= '0;
      fill_byte  <= '0;
      drain_idx  <= '0;
      drain_byte <= '0;
    end else begin
      if (fill_hs) begin
        fill_byte <= fill_last ? '0 : fill_byte + 1'b1;
        if (fill_last) fill_idx <= fill_idx + 1'b1;
      end
      if (drain_hs) begin
        drain_byte <= drain_last ? '0 : drain_byte + 1'b1;
        if (drain_last) drain_idx <= drain_idx + 1'b1;
      end
    end
  end

  // Buffer contents: stream bytes land in EMPTY buffers, field writes in FULL ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) mem[i] <= '0;
    end else begin
      if (fill_hs) mem[fill_idx][fill_base +: BUFFER_WIDTH] <= in_data;
      if (wr_ok)   mem[bufp] <= (mem[bufp] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Registered field read; sees contents from before any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) field_rdata <= '0;
    else        field_rdata <= rd_field;
  end

  // Per-buffer processor ownership flags.
  always_comb begin
    buf_full = '0;
    for (int n = 0; n < NBUF; n++) buf_full[n] = (state[n] == FULL);
  end

endmodule

// File: tb/tb_pattern_buf.sv
// Bench for pattern_buf: directed scenarios with literal expectations plus a
// randomized phase, all shadowed by a behavioural model checked every cycle.
module tb_pattern_buf;

  localparam int NB  = 8;
  localparam int BB  = 32;
  localparam int BPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] bufp;
  logic [4:0] fieldp, fieldwp;
  logic       field_we;
  logic [7:0] field_wdata, field_rdata;
  logic       buf_release;
  logic [7:0] buf_full;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pattern_buf dut (
    .clk(clk), .rst_n(rst_n), .bufp(bufp), .fieldp(fieldp), .fieldwp(fieldwp),
    .field_we(field_we), .field_wdata(field_wdata), .field_rdata(field_rdata),
    .buf_release(buf_release), .buf_full(buf_full),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buffer states as ints: 0 empty, 1 owned by processor, 2 released.
  logic [31:0] m_mem [NB];
  int          m_st  [NB];
  int          m_fi, m_fb, m_di, m_db;
  logic [7:0]  m_rd;
  logic [7:0]  t_rd;
  bit          t_in_hs, t_out_hs, t_wr, t_rel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin m_mem[i] = 32'h0; m_st[i] = 0; end
      m_fi = 0; m_fb = 0; m_di = 0; m_db = 0; m_rd = 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) t_rd[i] = m_mem[bufp][(int'(fieldp) + i) % BB];
      t_in_hs  = in_valid && (m_st[m_fi] == 0);
      t_out_hs = out_ready && (m_st[m_di] == 2);
      t_wr     = field_we && (m_st[bufp] == 1);
      t_rel    = buf_release && (m_st[bufp] == 1);
      m_rd = t_rd;
      if (t_wr)
        for (int i = 0; i < 8; i++) m_mem[bufp][(int'(fieldwp) + i) % BB] = field_wdata[i];
      if (t_rel) m_st[bufp] = 2;
      if (t_in_hs) begin
        m_mem[m_fi][8*m_fb +: 8] = in_data;
        if (m_fb == BPB - 1) begin m_st[m_fi] = 1; m_fb = 0; m_fi = (m_fi + 1) % NB; end
        else m_fb++;
      end
      if (t_out_hs) begin
        if (m_db == BPB - 1) begin m_st[m_di] = 0; m_db = 0; m_di = (m_di + 1) % NB; end
        else m_db++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  logic [7:0]  e_bf;
  logic [31:0] e_word;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int n = 0; n < NB; n++) e_bf[n] = (m_st[n] == 1);
      chk("m_buf_full", buf_full, e_bf);
      chk("m_in_ready", in_ready, m_st[m_fi] == 0);
      chk("m_out_valid", out_valid, m_st[m_di] == 2);
      chk("m_field_rdata", field_rdata, m_rd);
      if (m_st[m_di] == 2) begin
        e_word = m_mem[m_di];
        chk("m_out_data", out_data, e_word[8*m_db +: 8]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bufp = 3'd0; fieldp = 5'd0; fieldwp = 5'd0; field_we = 1'b0; field_wdata = 8'h00;
    buf_release = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
  endtask

  logic [7:0] seed_bytes [4];
  logic [7:0] drain_exp  [4];

  initial begin
    seed_bytes[0] = 8'h11; seed_bytes[1] = 8'h22; seed_bytes[2] = 8'h33; seed_bytes[3] = 8'h44;
    drain_exp[0]  = 8'h3F; drain_exp[1]  = 8'h22; drain_exp[2]  = 8'h33; drain_exp[3]  = 8'hC4;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_buf_full", buf_full, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_field_rdata", field_rdata, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Fill buffer 0.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_data = seed_bytes[k]; tick(); end
    in_valid = 1'b0;
    chk("fill_buf_full", buf_full, 8'h01);
    chk("fill_in_ready", in_ready, 1'b1);

    // Field reads, including wrap past the top bit.
    bufp = 3'd0; fieldp = 5'd4; tick();
    chk("read_off4", field_rdata, 8'h21);
    fieldp = 5'd28; tick();
    chk("read_wrap28", field_rdata, 8'h14);

    // Wrapping field write.
    field_we = 1'b1; fieldwp = 5'd30; field_wdata = 8'hFF; tick();
    field_we = 1'b0;
    fieldp = 5'd0; tick();
    chk("write_low", field_rdata, 8'h3F);
    fieldp = 5'd24; tick();
    chk("write_high", field_rdata, 8'hC4);

    // Release and drain with 3-cycle stalls per byte.
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, drain_exp[k]);
        tick();
      end
      chk("drain_data", out_data, drain_exp[k]);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    chk("drained_buf_full", buf_full, 8'h00);
    chk("drained_out_valid", out_valid, 1'b0);
    chk("drained_in_ready", in_ready, 1'b1);

    // Illegal write and release on an EMPTY buffer.
    bufp = 3'd2; field_we = 1'b1; fieldwp = 5'd0; field_wdata = 8'hAA; tick();
    field_we = 1'b0; fieldp = 5'd0; tick();
    chk("illegal_write", field_rdata, 8'h00);
    buf_release = 1'b1; tick(); buf_release = 1'b0;
    chk("illegal_rel_full", buf_full, 8'h00);
    chk("illegal_rel_valid", out_valid, 1'b0);

    // Fill every buffer, then try a 33rd byte.
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin in_data = 8'($urandom); tick(); end
    chk("all_full", buf_full, 8'hFF);
    chk("all_full_ready", in_ready, 1'b0);
    in_data = 8'h5A; tick();
    chk("byte33_ready", in_ready, 1'b0);
    chk("byte33_full", buf_full, 8'hFF);
    in_valid = 1'b0;

    // Head-of-line ordering: drain pointer sits on buffer 1.
    bufp = 3'd3; buf_release = 1'b1; tick(); buf_release = 1'b0; tick();
    chk("hol_blocked", out_valid, 1'b0);
    bufp = 3'd1; buf_release = 1'b1; tick(); buf_release = 1'b0;
    chk("hol_rel1_valid", out_valid, 1'b1);
    out_ready = 1'b1; repeat (4) tick(); out_ready = 1'b0;
    chk("hol_after_valid", out_valid, 1'b0);
    chk("hol_after_full", buf_full, 8'hF5);
    chk("hol_after_ready", in_ready, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bufp        = 3'($urandom);
      fieldp      = 5'($urandom);
      fieldwp     = 5'($urandom);
      field_wdata = 8'($urandom);
      field_we    = ($urandom_range(3) == 0);
      buf_release = ($urandom_range(2) == 0);
      in_valid    = ($urandom_range(3) != 0);
      in_data     = 8'($urandom);
      out_ready   = ($urandom_range(3) != 0);
      tick();
    end

    // Reset while the second byte of a drain is presented.
    idle_inputs();
    rst_n = 1'b0; #3; rst_n = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_data = seed_bytes[k]; tick(); end
    in_valid = 1'b0;
    bufp = 3'd0; buf_release = 1'b1; tick(); buf_release = 1'b0;
    chk("mid_byte0", out_data, 8'h11);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("mid_byte1", out_data, 8'h22);
    #2; rst_n = 1'b0; #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_full", buf_full, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;
    bufp = 3'd0; fieldp = 5'd0; tick();
    chk("post_rst_read0", field_rdata, 8'h00);
    fieldp = 5'd8; tick();
    chk("post_rst_read8", field_rdata, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
